fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Pipeline control block for the 5-stage MIPS datapath.
- Tracks the destination-register information of the instructions in the EX, MEM and WB stages.
- Drives the 2-bit select inputs of the two EX-stage 3-to-1 operand muxes:
  - 0 = register-file value
  - 1 = MEM/WB write-back value
  - 2 = EX/MEM ALU result
- Raises a load-use stall toward the PC/IF-ID registers and inserts the bubble into its own EX slot.

Parameters:
- REG_AW, 5, register address width.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  synchronous reset, active-high
- id_valid_i  input  1  ID stage holds a real instruction
- id_rs_i  input  REG_AW  ID source register rs
- id_rt_i  input  REG_AW  ID source register rt
- id_uses_rt_i  input  1  ID instruction reads rt (R-type, beq, sw)
- id_dst_i  input  REG_AW  ID destination (rd or rt after RegDst)
- id_regwrite_i  input  1  ID instruction writes the register file
- id_memread_i  input  1  ID instruction is a load
- flush_i  input  1  discard the ID instruction (taken branch/jump)
- forward_a_o  output  2  select for EX operand A mux
- forward_b_o  output  2  select for EX operand B mux
- stall_o  output  1  hold PC and IF/ID this cycle

Behaviour:
Internal state:
- EX slot: valid, rs, rt, dst, regwrite, memread.
- MEM slot: valid, dst, regwrite, memread.
- WB slot: valid, dst, regwrite.

Reset:
- rst_i=1 at a clock edge clears every valid and regwrite bit.
- forward_a_o=0, forward_b_o=0 and stall_o=0 from the first cycle after reset.
- Reset mid-stream discards all in-flight tracking; no forwarding until new instructions advance.

Per-cycle update (every edge with rst_i=0):
- WB <= MEM and MEM <= EX, unconditionally.
- EX <= bubble (all fields 0) if stall_o=1 or flush_i=1.
- Otherwise EX <= ID fields, with valid=id_valid_i.

Hazard detection (stall_o, combinational):
- stall_o = id_valid_i & ~flush_i & EX.valid & EX.memread & (EX.dst!=0) & ((EX.dst==id_rs_i) | (id_uses_rt_i & EX.dst==id_rt_i)).
- Flush has priority over stall: both insert a bubble, and stall_o stays 0 so the fetch redirect is not blocked.
- A single load-use stall lasts exactly 1 cycle. On the next cycle the load sits in MEM and the consumer is re-presented with EX holding the bubble, so stall_o=0.

Forwarding (forward_a_o, combinational from registered state):
- 2 if MEM.valid & MEM.regwrite & ~MEM.memread & MEM.dst!=0 & MEM.dst==EX.rs.
- Else 1 if WB.valid & WB.regwrite & WB.dst!=0 & WB.dst==EX.rs.
- Else 0.
- forward_b_o: same rule using EX.rt.
- A bubble or invalid EX slot forces both selects to 0.

Boundary rules:
- Register $0 is never forwarded and never causes a stall.
- When MEM and WB both match, MEM wins (most recent producer).
- A load in MEM is never forwarded from the ALU-result path; the stall guarantees it is in WB when consumed.
- Value 3 is never driven.
- Same-cycle WB write and ID read of one register is resolved by the register file (write-first), not here.
- Latency: selects are valid in the same cycle the consumer occupies EX; stall_o is valid in the same cycle the consumer occupies ID.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits) and output fwd_cnt_o (32 bits).
  - stall_cnt_o increments on every cycle with stall_o=1.
  - fwd_cnt_o increments on every cycle where forward_a_o!=0 or forward_b_o!=0 (by 1, not 2).
  - Both counters clear on rst_i and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_i 2 cycles with random ID inputs -> forward_a_o=0, forward_b_o=0, stall_o=0; with FWD_HAZARD_STATS_EN defined, stall_cnt_o=0.
- EX/MEM forward: issue add $3,$1,$2 then sub $4,$3,$5 back-to-back -> while sub is in EX, forward_a_o=2 and forward_b_o=0.
- MEM/WB forward and priority:
  - Issue add $3,..; nop; or $6,$7,$3 -> forward_b_o=1 while or is in EX.
  - Issue add $3; add $3; and $8,$3,$3 -> forward_a_o=forward_b_o=2.
- Load-use:
  - Issue lw $2,0($1) then add $4,$2,$5 -> stall_o=1 for exactly 1 cycle and EX holds a bubble.
  - Next cycle the add enters EX with forward_a_o=1.
  - stall_cnt_o=1 when FWD_HAZARD_STATS_EN is defined.
- $0 and flush:
  - Issue add $0,$1,$2 then sub $5,$0,$0 -> selects stay 0.
  - Issue lw $2 with the dependent add flushed (flush_i=1) -> stall_o=0, and the flushed instruction never forwards.
- Reset mid-operation: rst_i during a stall cycle, then independent instructions -> no stale forwards; all selects 0 until new producers advance.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the 5-stage MIPS pipeline.
// Optional event counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       fwd_cnt_o,
`endif
  output logic              stall_o
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
  } wb_slot_t;

  ex_slot_t  ex_q;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;

  logic load_hit;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // Destination tracking; a stall or flush turns the incoming EX entry into a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q.valid     <= mem_q.valid;
      wb_q.dst       <= mem_q.dst;
      wb_q.regwrite  <= mem_q.regwrite;
      mem_q.valid    <= ex_q.valid;
      mem_q.dst      <= ex_q.dst;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.memread  <= ex_q.memread;
      if (stall_o || flush_i) begin
        ex_q <= '0;
      end else begin
        ex_q.valid    <= id_valid_i;
        ex_q.rs       <= id_rs_i;
        ex_q.rt       <= id_rt_i;
        ex_q.dst      <= id_dst_i;
        ex_q.regwrite <= id_regwrite_i;
        ex_q.memread  <= id_memread_i;
      end
    end
  end

  // Load in EX feeding the instruction in ID; a flush wins so the redirect is never held.
  always_comb begin
    load_hit = ex_q.valid && ex_q.memread && (ex_q.dst != '0) &&
               ((ex_q.dst == id_rs_i) || (id_uses_rt_i && (ex_q.dst == id_rt_i)));
    stall_o  = id_valid_i && !flush_i && load_hit;
  end

  // A load in MEM has no ALU result to forward; the stall ensures it is consumed from WB.
  always_comb begin
    mem_fwd_ok  = mem_q.valid && mem_q.regwrite && !mem_q.memread && (mem_q.dst != '0);
    wb_fwd_ok   = wb_q.valid && wb_q.regwrite && (wb_q.dst != '0);
    forward_a_o = SEL_RF;
    forward_b_o = SEL_RF;
    if (ex_q.valid) begin
      if (mem_fwd_ok && (mem_q.dst == ex_q.rs)) begin
        forward_a_o = SEL_MEM;
      end else if (wb_fwd_ok && (wb_q.dst == ex_q.rs)) begin
        forward_a_o = SEL_WB;
      end
      if (mem_fwd_ok && (mem_q.dst == ex_q.rt)) begin
        forward_b_o = SEL_MEM;
      end else if (wb_fwd_ok && (wb_q.dst == ex_q.rt)) begin
        forward_b_o = SEL_WB;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  // Saturating event counters; one forward event per cycle regardless of operand count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (((forward_a_o != SEL_RF) || (forward_b_o != SEL_RF)) &&
          (fwd_cnt_o != {CNT_W{1'b1}})) begin
        fwd_cnt_o <= fwd_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule
